// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: register map, frame constants and FSM states shared by the SPI register bank
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] MAX_ADDR       = ADDR_DUTY;
    localparam int         FRAME_BITS     = 16;
    localparam logic [4:0] CNT_SAT        = 5'd17;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    function automatic logic addr_ok(input logic [6:0] a);
        return a <= MAX_ADDR;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer plus an edge-detect flop for one asynchronous SPI pin
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [2:0] ff;

    // reset to the idle pin level so releasing reset never produces an edge
    always_ff @(posedge clk or posedge rst)
        if (rst) ff <= {3{RST_VAL}};
        else     ff <= {ff[1:0], a};

    assign lvl  = ff[1];
    assign rise = ff[1] & ~ff[2];
    assign fall = ~ff[1] & ff[2];

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-slave write port into five 8-bit control registers; SPI_READBACK_EN adds register readback on cipo
module spi_reg_bank
    import spi_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        copi,
    input  logic        ncs,
    output logic        cipo,
    output logic        cipo_oe,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm,
    output logic [7:0]  duty
);

    logic        sclk_lvl, sclk_rise, sclk_fall;
    logic        copi_s, copi_rise, copi_fall;
    logic        ncs_lvl, ncs_rise, ncs_fall;
    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] sr;
    logic [7:0]  regs [0:4];

    spi_sync #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rst(rst), .a(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync #(.RST_VAL(1'b0)) u_copi (.clk(clk), .rst(rst), .a(copi), .lvl(copi_s), .rise(copi_rise), .fall(copi_fall));
    spi_sync #(.RST_VAL(1'b1)) u_ncs  (.clk(clk), .rst(rst), .a(ncs), .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

    // frame FSM: collect bits while selected, commit a well-formed write once on deselect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            for (int i = 0; i < 5; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE:
                    if (ncs_fall) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sr    <= '0;
                    end
                SHIFT:
                    if (ncs_fall) begin
                        cnt <= '0;
                        sr  <= '0;
                    end else if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        sr  <= {sr[14:0], copi_s};
                        cnt <= (cnt == CNT_SAT) ? cnt : cnt + 5'd1;
                    end
                COMMIT: begin
                    if (cnt == 5'(FRAME_BITS) && sr[15] && addr_ok(sr[14:8]))
                        regs[sr[10:8]] <= sr[7:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign en_out = {regs[ADDR_EN_OUT_HI[2:0]], regs[ADDR_EN_OUT_LO[2:0]]};
    assign en_pwm = {regs[ADDR_EN_PWM_HI[2:0]], regs[ADDR_EN_PWM_LO[2:0]]};
    assign duty   = regs[ADDR_DUTY[2:0]];

`ifdef SPI_READBACK_EN
    logic [6:0] rd_sh;
    logic       unused;

    assign unused = ^{copi_rise, copi_fall, sclk_lvl, ncs_lvl};

    // drive read data on sclk falls once the header byte is in; the controller samples on rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
            rd_sh   <= '0;
        end else if (ncs_rise) begin
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
        end else if (ncs_fall && state != COMMIT) begin
            cipo    <= 1'b0;
            cipo_oe <= 1'b1;
        end else if (state == SHIFT && sclk_fall) begin
            if (cnt == 5'd8)
                {cipo, rd_sh} <= (!sr[7] && addr_ok(sr[6:0])) ? regs[sr[2:0]] : 8'h00;
            else if (cnt > 5'd8 && cnt < 5'(FRAME_BITS))
                {cipo, rd_sh} <= {rd_sh, 1'b0};
        end
    end
`else
    logic unused;

    assign unused  = ^{copi_rise, copi_fall, sclk_lvl, ncs_lvl, sclk_fall};
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames with a queued scoreboard checked by an independent monitor
module tb_spi_reg_bank;

    logic        clk, rst, sclk, copi, ncs;
    logic        cipo, cipo_oe;
    logic [15:0] en_out, en_pwm;
    logic [7:0]  duty;
    logic [7:0]  rd_cap;
    int          checks = 0;
    int          errors = 0;

`ifdef SPI_READBACK_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif

    typedef struct {
        int          kind;
        string       name;
        logic [39:0] want;
    } item_t;

    item_t       q[$];
    item_t       it;
    logic [39:0] act;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .en_out(en_out), .en_pwm(en_pwm), .duty(duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: pop one expectation per falling edge and compare against the DUT
    always @(negedge clk) begin
        if (q.size() > 0) begin
            it = q.pop_front();
            case (it.kind)
                0:       act = {en_out, en_pwm, duty};
                1:       act = {32'h0, rd_cap};
                2:       act = {39'h0, cipo_oe};
                default: act = {39'h0, cipo};
            endcase
            checks++;
            if (act !== it.want) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.want);
            end
        end
    end

    task automatic chk(input int kind, input string name, input logic [39:0] want);
        item_t e;
        @(posedge clk);
        e.kind = kind;
        e.name = name;
        e.want = want;
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b, output logic o);
        copi = b;
        repeat (4) @(negedge clk);
        o = cipo;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [31:0] w, input int n, input bit mid_oe);
        logic o;
        rd_cap = 8'h00;
        @(negedge clk);
        ncs = 1'b0;
        if (mid_oe) begin
            repeat (3) @(posedge clk);
            chk(2, "oe_mid", {39'h0, RB});
        end else begin
            repeat (4) @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            send_bit(w[31-i], o);
            if (i >= 8 && i < 16) rd_cap[15-i] = o;
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic wr(input logic [15:0] w, input int n, input string name, input logic [39:0] want);
        frame({w, 16'h0}, n, 1'b0);
        chk(0, name, want);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic o;
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; rd_cap = 8'h00;
        repeat (2) @(posedge clk);
        chk(0, "rst_regs", 40'h0);
        chk(2, "rst_oe", 40'h0);
        chk(3, "rst_cipo", 40'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        wr(16'h80F0, 16, "wr_en_out_lo", {16'h00F0, 16'h0000, 8'h00});
        wr(16'h8480, 16, "wr_duty",      {16'h00F0, 16'h0000, 8'h80});
        wr(16'hB0AA, 16, "wr_bad_addr",  {16'h00F0, 16'h0000, 8'h80});
        wr(16'h8255, 15, "short_frame",  {16'h00F0, 16'h0000, 8'h80});
        wr(16'h8255, 16, "wr_en_pwm_lo", {16'h00F0, 16'h0055, 8'h80});
        frame({16'h8133, 1'b1, 15'h0}, 17, 1'b0);
        chk(0, "long_frame", {16'h00F0, 16'h0055, 8'h80});
        repeat (4) @(posedge clk);

        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(1'(16'h8177 >> (15 - i)), o);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk(0, "rst_mid", 40'h0);
        for (int i = 8; i < 16; i++) send_bit(1'(16'h8177 >> (15 - i)), o);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (3) @(posedge clk);
        chk(0, "rst_after", 40'h0);
        repeat (4) @(posedge clk);
        wr(16'h8177, 16, "wr_fresh", {16'h7700, 16'h0000, 8'h00});

        wr(16'h83A5, 16, "wr_en_pwm_hi", {16'h7700, 16'hA500, 8'h00});
        frame({16'h0300, 16'h0}, 16, 1'b1);
        chk(1, "rd_byte", {32'h0, (RB ? 8'hA5 : 8'h00)});
        chk(2, "oe_after", 40'h0);
        chk(0, "rd_regs", {16'h7700, 16'hA500, 8'h00});
        repeat (4) @(posedge clk);
        frame({16'h3000, 16'h0}, 16, 1'b1);
        chk(1, "rd_bad_addr", 40'h0);
        chk(0, "rd_bad_regs", {16'h7700, 16'hA500, 8'h00});

        repeat (10) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL expose: clk  input  1  system clock (10 MHz nominal); all state is clocked on its rising edge.
REQ-002 SHALL expose: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: sclk  input  1  SPI clock from the chip pin, asynchronous to clk.
REQ-004 SHALL expose: copi  input  1  SPI controller-out data from the pin, asynchronous.
REQ-005 SHALL expose: ncs  input  1  SPI chip select from the pin, active-low, asynchronous.
REQ-006 SHALL expose: cipo  output  1  SPI read data; cipo_oe  output  1  its output enable.
REQ-007 SHALL expose: en_out  output  16  output-enable bits, {reg1, reg0}.
REQ-008 SHALL expose: en_pwm  output  16  PWM-mode bits, {reg3, reg2}.
REQ-009 SHALL expose: duty  output  8  PWM duty cycle (reg4), consumed by the downstream PWM generator.

Function
REQ-010 SHALL pass sclk, copi and ncs each through a 2-flop synchronizer, then a third flop for edge detection; sclk rise, sclk fall, ncs fall and ncs rise are single-clk pulses.
REQ-011 SHALL run FSM IDLE -> SHIFT on ncs fall; SHIFT -> COMMIT on ncs rise; COMMIT -> IDLE after one cycle unconditionally.
REQ-012 SHALL, in SHIFT, shift synchronized copi MSB-first into a 16-bit register on each sclk rise and increment a 5-bit bit counter, saturating at 17.
REQ-013 SHALL interpret the frame as bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-014 SHALL, in COMMIT, write data to the addressed register only if counter == 16, R/W == 1 and address <= 0x04; otherwise no register changes.
REQ-015 SHALL make the new register value visible on its output within 4 clk cycles of ncs rising at the pin.
REQ-016 SHALL silently discard frames with address > 0x04, with fewer than 16 bits, or with more than 16 bits.
REQ-017 SHALL treat ncs fall during SHIFT (glitch/back-to-back) as a new frame: counter and shift register cleared, no commit.
REQ-018 SHALL ignore sclk edges while in IDLE or COMMIT.
REQ-019 SHALL require sclk <= clk/5 for correct capture; behaviour above that is undefined.

Reset
REQ-020 SHALL, while rst is high, force FSM to IDLE, counter and shift register to 0, en_out, en_pwm and duty to 0x0000/0x0000/0x00, cipo and cipo_oe to 0.
REQ-021 SHALL, on rst asserted mid-frame, drop the frame; after rst deasserts the block waits for the next ncs fall.
REQ-022 SHALL clear synchronizer flops on reset to values representing sclk=0, copi=0, ncs=1, so no spurious edge follows reset release.

Configuration
REQ-023 SHALL provide macro SPI_READBACK_EN; when defined, a frame with R/W == 0 and address <= 0x04 drives cipo with the addressed register MSB-first, one bit per sclk fall during bits 8..15, with cipo_oe high from ncs fall until ncs rise; invalid-address reads return 0x00.
REQ-024 SHALL, when SPI_READBACK_EN is undefined, tie cipo and cipo_oe to 0 and treat reads as discarded frames.

Structure
REQ-025 SHALL place address constants (ADDR_EN_OUT_LO=0x00 ... ADDR_DUTY=0x04), MAX_ADDR, FRAME_BITS=16 and the FSM state enum in package spi_reg_pkg.
REQ-026 SHALL implement the synchronizer + edge detector as one sub-module, spi_sync, instantiated once per SPI input.

Verification
REQ-027 SHALL verify: write 0x80 0xF0 (addr 0, data 0xF0), then ncs rise -> en_out = 0x00F0 within 4 clk.
REQ-028 SHALL verify: write addr 0x04 data 0x80 -> duty = 0x80; en_out/en_pwm unchanged.
REQ-029 SHALL verify: write addr 0x30 data 0xAA -> all outputs unchanged.
REQ-030 SHALL verify: 15-bit frame (write addr 2 data 0x55 minus last bit) -> en_pwm unchanged; following full 16-bit write to addr 2 with data 0x55 -> en_pwm = 0x0055.
REQ-031 SHALL verify: rst pulse after 8 of 16 bits, then complete frame -> no write; fresh frame afterwards commits normally.
REQ-032 SHALL verify (SPI_READBACK_EN): after write addr 3 data 0xA5, read addr 3 -> cipo shifts 1010_0101 on bits 8..15, en_pwm = 0xA500, cipo_oe high only while ncs low.
